// File: rtl/display_scanner_pkg.sv
// display_scanner_pkg: shared nibble type and digit-enable helper for the display scanner.
package display_scanner_pkg;

   localparam int NIBBLE_W = 4;

   typedef logic [NIBBLE_W-1:0] nibble_t;

   function automatic logic [31:0] an_onehot(input int unsigned idx, input logic active_low);
      logic [31:0] oh;
      oh = 32'd1 << idx;
      return active_low ? ~oh : oh;
   endfunction

endpackage

// File: rtl/display_scanner_tick_divider.sv
// tick_divider: free-running prescaler producing a one-cycle strobe every DIV clocks.
module tick_divider
   import display_scanner_pkg::*;
#(
   parameter int DIV = 50000
) (
   input  logic clk,
   input  logic rst_n,
   output logic tick
);

   localparam int W = DIV > 1 ? $clog2(DIV) : 1;
   localparam logic [W-1:0] LAST = W'(DIV - 1);

   logic [W-1:0] prescaler;

   assign tick = prescaler == LAST;

   always_ff @(posedge clk)
      if (!rst_n) prescaler <= '0;
      else prescaler <= tick ? '0 : prescaler + 1'b1;

endmodule

// File: rtl/display_scanner.sv
// display_scanner: time-multiplexed seven-segment digit scanner with frame-aligned value updates
// and optional leading-zero blanking.
module display_scanner
   import display_scanner_pkg::*;
#(
   parameter int NUM_DIGITS    = 4,
   parameter int REFRESH_DIV   = 50000,
   parameter int AN_ACTIVE_LOW = 1
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           load,
   input  logic [NIBBLE_W*NUM_DIGITS-1:0] value,
   input  logic                           blank_lz,
   output logic                           ready,
   output nibble_t                        hex,
   output logic [NUM_DIGITS-1:0]          an,
   output logic                           blank,
   output logic                           frame_done
);

   localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
   localparam int VW = NIBBLE_W * NUM_DIGITS;
   localparam logic [IW-1:0] LAST = IW'(NUM_DIGITS - 1);
   localparam logic [NUM_DIGITS-1:0] AN_OFF = AN_ACTIVE_LOW != 0 ? '1 : '0;

   logic                  tick, wrap, pend_v, run, lz;
   logic [IW-1:0]         idx;
   logic [VW-1:0]         disp, pend;
   logic [NUM_DIGITS-1:0] zero_hi, an_nxt;

   tick_divider #(.DIV(REFRESH_DIV)) u_div (
      .clk   (clk),
      .rst_n (rst_n),
      .tick  (tick)
   );

   assign wrap   = tick && idx == LAST;
   // pend_v is registered, so ready is effectively a registered output
   assign ready  = !pend_v;
   assign an_nxt = NUM_DIGITS'(an_onehot(32'(idx), AN_ACTIVE_LOW != 0));

   // zero_hi[k]: every nibble from k up to the most-significant digit is zero
   always_comb begin
      run     = 1'b1;
      zero_hi = '0;
      for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
         run        = run && disp[k*NIBBLE_W +: NIBBLE_W] == '0;
         zero_hi[k] = run;
      end
   end

   assign lz = blank_lz && idx != '0 && zero_hi[idx];

   always_ff @(posedge clk)
      if (!rst_n) begin
         idx        <= '0;
         disp       <= '0;
         pend       <= '0;
         pend_v     <= 1'b0;
         hex        <= '0;
         an         <= AN_OFF;
         blank      <= 1'b1;
         frame_done <= 1'b0;
      end else begin
         if (tick) idx <= idx == LAST ? '0 : idx + 1'b1;
         if (load && ready) begin
            pend   <= value;
            pend_v <= 1'b1;
         end else if (wrap && pend_v) begin
            disp   <= pend;
            pend_v <= 1'b0;
         end
         hex        <= disp[idx*NIBBLE_W +: NIBBLE_W];
         an         <= an_nxt;
         blank      <= lz;
         frame_done <= wrap;
      end

endmodule

// File: tb/tb_display_scanner.sv
// tb_display_scanner: directed checks of scan order, handshake, frame-aligned commit and blanking.
module tb_display_scanner;

   logic        clk = 1'b0, rst_n = 1'b0, load = 1'b0, blank_lz = 1'b0;
   logic [15:0] value = '0;
   logic        ready, blank, frame_done;
   logic [3:0]  hex, an;
   int          vectors = 0, errors = 0, n = 0;

   logic [15:0] vals  [3] = '{16'h0007, 16'h0000, 16'h0300};
   logic [3:0]  masks [3] = '{4'b1110, 4'b1110, 4'b1000};

   always #5 clk = ~clk;

   display_scanner #(.NUM_DIGITS(4), .REFRESH_DIV(4), .AN_ACTIVE_LOW(1)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (load),
      .value      (value),
      .blank_lz   (blank_lz),
      .ready      (ready),
      .hex        (hex),
      .an         (an),
      .blank      (blank),
      .frame_done (frame_done)
   );

   // n counts clock edges since reset release; digit on outputs after edge n
   function automatic int dig(input int c);
      return ((c - 1) / 4) % 4;
   endfunction

   task automatic step();
      @(negedge clk);
      n++;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; load = 1'b0; blank_lz = 1'b0;
      step(); step();
      rst_n = 1'b1;
      n = 0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; load = 1'b0;
      step(); step();
      vectors++; if (an !== 4'b1111) begin errors++; $display("FAIL reset_an: got %b want 1111", an); end
      vectors++; if (hex !== 4'h0) begin errors++; $display("FAIL reset_hex: got %h want 0", hex); end
      vectors++; if (blank !== 1'b1) begin errors++; $display("FAIL reset_blank: got %b want 1", blank); end
      vectors++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", ready); end
      vectors++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
   endtask

   task automatic test_scan();
      logic [3:0] ea;
      do_reset();
      for (int i = 1; i <= 20; i++) begin
         step();
         ea = ~(4'b0001 << dig(n));
         vectors++;
         if (an !== ea || hex !== 4'h0 || blank !== 1'b0 || frame_done !== (n == 16)) begin
            errors++;
            $display("FAIL scan n=%0d: an=%b hex=%h blank=%b fd=%b want an=%b hex=0 blank=0 fd=%b",
                     n, an, hex, blank, frame_done, ea, n == 16);
         end
      end
   endtask

   task automatic test_load();
      logic [15:0] ev;
      logic [3:0]  eh;
      ev = 16'h1A3F;
      do_reset();
      step();
      vectors++; if (ready !== 1'b1) begin errors++; $display("FAIL load_ready_idle: got %b want 1", ready); end
      load = 1'b1; value = 16'h1A3F; step(); load = 1'b0;
      vectors++; if (ready !== 1'b0) begin errors++; $display("FAIL load_ready_fall: got %b want 0", ready); end
      load = 1'b1; value = 16'hBEEF; step(); load = 1'b0;
      vectors++; if (ready !== 1'b0) begin errors++; $display("FAIL load_ignored_ready: got %b want 0", ready); end
      while (n < 15) begin
         step();
         vectors++; if (hex !== 4'h0) begin errors++; $display("FAIL load_old_frame n=%0d: hex=%h want 0", n, hex); end
      end
      step();
      vectors++;
      if (ready !== 1'b1 || frame_done !== 1'b1 || hex !== 4'h0) begin
         errors++;
         $display("FAIL load_wrap: ready=%b fd=%b hex=%h want 1 1 0", ready, frame_done, hex);
      end
      for (int f = 0; f < 2; f++)
         for (int i = 0; i < 16; i++) begin
            step();
            eh = ev[dig(n)*4 +: 4];
            vectors++;
            if (hex !== eh || an !== 4'(~(4'b0001 << dig(n)))) begin
               errors++;
               $display("FAIL load_new_frame n=%0d: hex=%h an=%b want hex=%h", n, hex, an, eh);
            end
         end
   endtask

   task automatic test_blank();
      logic [15:0] v;
      logic [3:0]  m, eh;
      logic        eb;
      do_reset();
      blank_lz = 1'b1;
      for (int j = 0; j < 3; j++) begin
         v = vals[j];
         m = masks[j];
         load = 1'b1; value = v; step(); load = 1'b0;
         vectors++; if (ready !== 1'b0) begin errors++; $display("FAIL blank_accept j=%0d: ready=%b want 0", j, ready); end
         while (n % 16 != 0) step();
         vectors++; if (ready !== 1'b1) begin errors++; $display("FAIL blank_commit j=%0d: ready=%b want 1", j, ready); end
         for (int i = 0; i < 16; i++) begin
            step();
            eh = v[dig(n)*4 +: 4];
            eb = m[dig(n)];
            vectors++;
            if (hex !== eh || blank !== eb || an !== 4'(~(4'b0001 << dig(n)))) begin
               errors++;
               $display("FAIL blank j=%0d n=%0d: hex=%h blank=%b an=%b want hex=%h blank=%b",
                        j, n, hex, blank, an, eh, eb);
            end
         end
      end
      blank_lz = 1'b0;
   endtask

   task automatic test_wrap_load();
      do_reset();
      while (n < 15) step();
      load = 1'b1; value = 16'h5555; step(); load = 1'b0;
      vectors++;
      if (frame_done !== 1'b1 || ready !== 1'b0) begin
         errors++;
         $display("FAIL wrap_load_accept: fd=%b ready=%b want 1 0", frame_done, ready);
      end
      for (int i = 0; i < 16; i++) begin
         step();
         vectors++; if (hex !== 4'h0) begin errors++; $display("FAIL wrap_load_early n=%0d: hex=%h want 0", n, hex); end
      end
      vectors++; if (ready !== 1'b1) begin errors++; $display("FAIL wrap_load_commit: ready=%b want 1", ready); end
      for (int i = 0; i < 16; i++) begin
         step();
         vectors++; if (hex !== 4'h5) begin errors++; $display("FAIL wrap_load_late n=%0d: hex=%h want 5", n, hex); end
      end
   endtask

   task automatic test_reset_mid();
      logic [3:0] ea;
      do_reset();
      load = 1'b1; value = 16'h1234; step(); load = 1'b0;
      while (n < 6) step();
      rst_n = 1'b0; step();
      vectors++; if (an !== 4'b1111) begin errors++; $display("FAIL midrst_an: got %b want 1111", an); end
      vectors++; if (blank !== 1'b1) begin errors++; $display("FAIL midrst_blank: got %b want 1", blank); end
      vectors++; if (ready !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %b want 1", ready); end
      vectors++; if (hex !== 4'h0) begin errors++; $display("FAIL midrst_hex: got %h want 0", hex); end
      rst_n = 1'b1;
      n = 0;
      for (int i = 0; i < 32; i++) begin
         step();
         ea = ~(4'b0001 << dig(n));
         vectors++;
         if (hex !== 4'h0 || an !== ea || ready !== 1'b1) begin
            errors++;
            $display("FAIL midrst_after n=%0d: hex=%h an=%b ready=%b want hex=0 an=%b ready=1", n, hex, an, ready, ea);
         end
      end
   endtask

   initial begin
      test_reset();
      test_scan();
      test_load();
      test_blank();
      test_wrap_load();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/display_scanner.md
Name: display_scanner

Overview:
- Time-multiplexed scan controller for a common-anode multi-digit seven-segment display.
- Holds a 16-bit display value and selects one digit per refresh slot.
- Drives that digit's 4-bit nibble to the downstream hex-to-seven-segment decoder and asserts the matching digit enable.
- New values load through a ready/load handshake and take effect only at frame boundaries, so a frame never mixes old and new digits.

Parameters:
- NUM_DIGITS, 4, number of digits scanned; display value width is 4*NUM_DIGITS.
- REFRESH_DIV, 50000, clock cycles per digit slot; legal range is 2 or more.
- AN_ACTIVE_LOW, 1, 1 means digit enables are active-low (common anode); 0 means active-high.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- load  in  1  request to load value; accepted on any cycle where load && ready.
- value  in  4*NUM_DIGITS  new display value; nibble k belongs to digit k, and digit 0 is the least-significant digit.
- blank_lz  in  1  enables leading-zero blanking; sampled every cycle.
- ready  out  1  high when the pending buffer is empty and a load can be accepted.
- hex  out  4  nibble for the currently enabled digit; feeds the decoder.
- an  out  NUM_DIGITS  one-hot digit enable, with polarity set by AN_ACTIVE_LOW.
- blank  out  1  high when the current digit must show nothing; the downstream logic forces segments off.
- frame_done  out  1  one-cycle pulse when a full scan of all digits completes.

Behaviour:
- Reset (rst_n low at a clk edge): all state and outputs take these values:
  - prescaler = 0, idx = 0, disp = 0, pend = 0, pend_v = 0
  - ready = 1, hex = 0, blank = 1, frame_done = 0
  - an = all inactive (all ones if AN_ACTIVE_LOW, else all zeros)
  - Reset mid-frame or mid-handshake discards any pending value.
- Prescaler:
  - Counts 0..REFRESH_DIV-1, then wraps to 0.
  - tick = (prescaler == REFRESH_DIV-1), a combinational internal signal.
- Digit index:
  - idx (clog2(NUM_DIGITS) bits) increments on tick and wraps from NUM_DIGITS-1 to 0.
  - wrap = tick && idx == NUM_DIGITS-1.
- Outputs (hex, an, blank) are registered from the current idx and disp. Latency is 1 cycle.
  - First active output is digit 0, in the cycle after rst_n rises.
  - An idx change on a tick appears on outputs one cycle later.
  - hex = disp[4*idx +: 4].
  - an = one-hot(idx), inverted when AN_ACTIVE_LOW.
- Leading-zero blanking:
  - Digit idx is blanked when blank_lz == 1, idx != 0, and every nibble from idx through NUM_DIGITS-1 is 0.
  - Digit 0 is never blanked, so a value of 0 displays "0".
  - When blanked, hex still carries the nibble (0) and an still enables the digit.
- frame_done: registered; equals 1 on the cycle after wrap.
- Handshake:
  - load && ready: pend <= value, pend_v <= 1, ready <= 0 (ready is registered; it reads 0 from the next cycle).
  - load while ready == 0 is ignored; the value is dropped and no error is flagged.
  - On wrap with pend_v == 1: disp <= pend, pend_v <= 0, ready <= 1 on the next cycle. The new value appears from digit 0 of the following frame.
  - Load accepted on the same cycle as wrap with pend_v == 0: the value goes to pend only and commits at the next wrap, not the current one.
- Arithmetic: all counters are unsigned, wrap explicitly, and have no overflow beyond the stated ranges.

Decomposition:
- Shared package holds:
  - NIBBLE_W = 4.
  - nibble_t typedef.
  - Helper function an_onehot(idx, active_low).
- Natural sub-module: tick_divider (parameter DIV; ports clk, rst_n, tick).
  - Reusable for other slow strobes in the design.
- Leading-zero logic stays inline as a combinational loop over nibbles.

Test Plan (NUM_DIGITS=4, REFRESH_DIV=4, AN_ACTIVE_LOW=1):
- Reset then run 20 cycles with no load:
  - hex=0 throughout.
  - an steps 1110, 1101, 1011, 0111, each held 4 cycles.
  - frame_done pulses once at cycle 17.
  - blank=0 throughout (blank_lz=0).
- Load 16'h1A3F at cycle 2:
  - ready falls at cycle 3.
  - Digits display 0 until the first wrap.
  - Next frame shows hex F, 3, A, 1 on digits 0..3.
  - ready returns to 1 the cycle after wrap.
- Second load asserted while ready=0:
  - Ignored; the first value is displayed.
  - pend is unchanged.
- Load 16'h0007 with blank_lz=1:
  - Digit 0 shows 7 with blank=0.
  - Digits 1..3 have blank=1.
  - Then load 16'h0000: digit 0 has blank=0, hex=0; digits 1..3 have blank=1.
  - Then load 16'h0300: digits 0,1,2 unblanked, digit 3 blanked.
- Load asserted exactly on a wrap cycle with pend_v=0:
  - Value is not shown in the immediately following frame.
  - Value appears one frame later.
- rst_n pulsed low mid-frame with pend_v=1:
  - Next cycle: an=1111, blank=1, ready=1.
  - After release, scanning restarts at digit 0 with disp=0.
  - Pending value is lost.
